// File: rtl/regfile_param_if.sv
// Decoder-side bus for regfile_param: write port, packed read ports and clear status.
// Signal suffixes are from the register file's point of view.
interface regfile_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]         rd_i;
  logic [XLEN-1:0]       datard_i;
  logic                  wren_i;
  logic [NREAD*AW-1:0]   rs_i;
  logic [NREAD*XLEN-1:0] datars_o;
  logic                  busy_o;
  logic                  clr_done_o;

  // Decoder / writeback side.
  modport master (
    output rd_i, datard_i, wren_i, rs_i,
    input  datars_o, busy_o, clr_done_o
  );

  // Register file side.
  modport slave (
    input  rd_i, datard_i, wren_i, rs_i,
    output datars_o, busy_o, clr_done_o
  );
endinterface

// File: rtl/regfile_param.sv
// Integer register bank: one synchronous write port, NREAD combinational read ports, r0 = 0,
// post-reset clear sequencer. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  regfile_param_if.slave  bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0 || NREAD < 1 || NREAD > 4) begin : g_bad_cfg
    $error("regfile_param: NREGS must be a power of 2 >= 2 and NREAD in 1..4");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            busy;
  logic            clr_done;

  // The clear sequencer and the architectural write share a single array write port.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_addr  = clr_cnt_q;
    mem_wdata = '0;
    busy      = 1'b0;
    clr_done  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          clr_done = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.wren_i && bus.rd_i != '0) begin
          mem_we    = 1'b1;
          mem_addr  = bus.rd_i;
          mem_wdata = bus.datard_i;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: the array is deliberately left without reset so it maps onto distributed RAM;
  // the clear sequencer provides defined contents instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      regs_q[mem_addr] <= mem_wdata;
    end
  end

  assign bus.busy_o     = busy;
  assign bus.clr_done_o = clr_done;

  for (genvar k = 0; k < NREAD; k++) begin : g_rport
    logic [AW-1:0]   rs_k;
    logic [XLEN-1:0] rdata_k;

    assign rs_k = bus.rs_i[k*AW +: AW];

    // Contents are untrusted until the clear finishes, so reads are forced to zero while busy.
    always_comb begin
      rdata_k = regs_q[rs_k];
      if (state_q != ST_RUN || rs_k == '0) begin
        rdata_k = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (bus.wren_i && bus.rd_i == rs_k) begin
        rdata_k = bus.datard_i;
      end
`endif
    end

    assign bus.datars_o[k*XLEN +: XLEN] = rdata_k;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param (XLEN=32, NREGS=32, NREAD=2): stimulus queues expected
// values, a negedge monitor pops and compares them against the live outputs.
module tb_regfile_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum int {F_RS0, F_RS1, F_BUSY, F_DONE} field_e;
  typedef struct {
    string       tag;
    field_e      field;
    logic [31:0] exp;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  regfile_param_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [NREGS];

  task automatic expect_val(input string tag, input field_e f, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.field = f;
    e.exp   = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [AW-1:0] a, input logic [31:0] d);
    bus.wren_i   = en;
    bus.rd_i     = a;
    bus.datard_i = d;
  endtask

  task automatic drive_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rs_i = {a1, a0};
  endtask

  // Full clear from a freshly released reset: busy for 32 windows, done only in the last.
  task automatic run_clear(input string tag);
    for (int c = 1; c <= NREGS; c++) begin
      expect_val({tag, "_busy"}, F_BUSY, 32'd1);
      expect_val({tag, "_done"}, F_DONE, (c == NREGS) ? 32'd1 : 32'd0);
      tick();
    end
    expect_val({tag, "_run_busy"}, F_BUSY, 32'd0);
    expect_val({tag, "_run_done"}, F_DONE, 32'd0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < NREGS; a++) begin
      drive_rs(AW'(a), AW'(NREGS - 1 - a));
      expect_val({tag, "_p0"}, F_RS0, mdl[a]);
      expect_val({tag, "_p1"}, F_RS1, mdl[NREGS - 1 - a]);
      tick();
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is checked mid-cycle.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.field)
        F_RS0:   act = bus.datars_o[31:0];
        F_RS1:   act = bus.datars_o[63:32];
        F_BUSY:  act = {31'd0, bus.busy_o};
        default: act = {31'd0, bus.clr_done_o};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", e.tag, act, e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    drive_wr(1'b0, '0, '0);
    drive_rs('0, '0);
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;

    // Reset held three cycles.
    repeat (2) tick();
    expect_val("rst_busy", F_BUSY, 32'd1);
    expect_val("rst_done", F_DONE, 32'd0);
    expect_val("rst_rs0", F_RS0, 32'd0);
    tick();
    rst_i = 1'b0;

    // Clear sequence, with an ignored write to r3 in clear cycle 10.
    for (int c = 1; c <= NREGS; c++) begin
      if (c == 10) begin
        drive_wr(1'b1, 5'd3, 32'hFFFF_FFFF);
        drive_rs(5'd3, 5'd3);
        expect_val("clr_rd_r3", F_RS0, 32'd0);
      end else begin
        drive_wr(1'b0, '0, '0);
      end
      expect_val("clr_busy", F_BUSY, 32'd1);
      expect_val("clr_done", F_DONE, (c == NREGS) ? 32'd1 : 32'd0);
      tick();
    end
    expect_val("run_busy", F_BUSY, 32'd0);
    expect_val("run_done", F_DONE, 32'd0);
    drive_rs(5'd3, 5'd0);
    expect_val("r3_after_clr", F_RS0, 32'd0);
    tick();
    read_all("clr_all");

    // Write/read on both ports.
    drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive_rs(5'd5, 5'd5);
    expect_val("wr5_same", F_RS0, BYP ? 32'hDEAD_BEEF : 32'd0);
    tick();
    mdl[5] = 32'hDEAD_BEEF;
    drive_wr(1'b0, '0, '0);
    expect_val("rd5_p0", F_RS0, 32'hDEAD_BEEF);
    expect_val("rd5_p1", F_RS1, 32'hDEAD_BEEF);
    tick();

    // Writes to r0 are dropped, bypass included.
    drive_wr(1'b1, 5'd0, 32'h1234_5678);
    drive_rs(5'd0, 5'd0);
    expect_val("r0_wr_p0", F_RS0, 32'd0);
    expect_val("r0_wr_p1", F_RS1, 32'd0);
    tick();
    drive_wr(1'b0, '0, '0);
    repeat (3) begin
      expect_val("r0_hold", F_RS0, 32'd0);
      tick();
    end

    // Same-cycle read-after-write on r7; port 1 on r5 must not see the forward.
    drive_wr(1'b1, 5'd7, 32'h1);
    tick();
    mdl[7] = 32'h1;
    drive_wr(1'b1, 5'd7, 32'h2);
    drive_rs(5'd7, 5'd5);
    expect_val("raw_r7", F_RS0, BYP ? 32'h2 : 32'h1);
    expect_val("raw_other", F_RS1, 32'hDEAD_BEEF);
    tick();
    mdl[7] = 32'h2;
    drive_wr(1'b0, '0, '0);
    expect_val("raw_r7_after", F_RS0, 32'h2);
    tick();

    // Distinct pattern in every register, then full readback.
    for (int a = 1; a < NREGS; a++) begin
      drive_wr(1'b1, AW'(a), {8'(a), ~8'(a), 8'h5A, 8'(a * 3)});
      tick();
      mdl[a] = {8'(a), ~8'(a), 8'h5A, 8'(a * 3)};
    end
    drive_wr(1'b0, '0, '0);
    read_all("pattern");

    // Reset again, then re-assert it in clear cycle 15.
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    for (int c = 1; c < 15; c++) begin
      expect_val("mid_busy", F_BUSY, 32'd1);
      expect_val("mid_done", F_DONE, 32'd0);
      tick();
    end
    rst_i = 1'b1;
    expect_val("mid_rst_busy", F_BUSY, 32'd1);
    expect_val("mid_rst_done", F_DONE, 32'd0);
    tick();
    rst_i = 1'b0;
    run_clear("restart");
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    read_all("restart_all");

    @(negedge clk_i);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
